parser_type_lookup: RTL and testbench
=====================================

# parser_type_lookup

Parametrised type-rule lookup engine for one parser layer. It takes the TYPE_NUM type fields extracted from the packet head and matches them against RULE_NUM masked rules, lowest index first. It returns the winning rule's action word: key offsets, head shift and meta shift. Rules live in a double-banked table; control-plane edits go to a shadow bank and are committed atomically, so in-flight lookups never see a half-written rule set. Per-rule saturating hit counters and a miss counter are readable in-band.

## Interface
- TYPE_NUM, 2, number of type fields compared per lookup
- TYPE_WIDTH, 8, bits per type field
- RULE_NUM, 8, rule entries per bank (≥2)
- ACT_WIDTH, 64, action word width (key offsets + headShift + metaShift, packed by caller)
- CNT_WIDTH, 32, hit/miss counter width
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_type_valid  in  1  lookup request
- i_type_data  in  TYPE_NUM*TYPE_WIDTH  type fields, field t at [t*TYPE_WIDTH +: TYPE_WIDTH]
- o_act_valid  out  1  result valid
- o_act_hit  out  1  a rule matched
- o_act_idx  out  $clog2(RULE_NUM)  winning rule index (0 on miss)
- o_act_data  out  ACT_WIDTH  winning action (0 on miss)
- i_cfg_wr  in  1  shadow-bank write strobe
- i_cfg_addr  in  $clog2(RULE_NUM)  rule index
- i_cfg_rule  in  lookup_rule_t  {valid, data, mask, action}
- i_cfg_commit  in  1  swap banks
- o_cfg_ready  out  1  write/commit accepted this cycle
- i_cnt_rd  in  1  counter read strobe
- i_cnt_addr  in  $clog2(RULE_NUM+1)  0..RULE_NUM-1 = rule, RULE_NUM = miss
- i_cnt_clr  in  1  clear-on-read qualifier
- o_cnt_valid  out  1  read data valid
- o_cnt_data  out  CNT_WIDTH  counter value

## Operation
- Match for rule r: the rule's valid bit is set and, for every field t, (type[t] & mask[t]) == (data[t] & mask[t]). A mask of 0 makes that field a wildcard.
- Priority: the lowest matching index wins. If no rule matches, the result is a miss: hit=0, idx=0, data=0.
- Banks: active_sel selects the bank used by lookups. i_cfg_wr writes the shadow bank only.
- Config FSM states are IDLE and COPY.
  - IDLE: o_cfg_ready=1. A write updates the shadow entry. A commit toggles active_sel and moves to COPY with copy_ptr=0.
  - COPY: o_cfg_ready=0. Each cycle, shadow[copy_ptr] ← active[copy_ptr] and copy_ptr increments. After RULE_NUM cycles the FSM returns to IDLE.
  - After COPY, incremental edits start from the live rule set.
  - Writes and commits issued while o_cfg_ready=0 are dropped. The caller must hold them until ready.
  - Write and commit in the same IDLE cycle: the write lands in the old shadow first, then the commit swaps, so the written rule goes live.
- Counters: on each o_act_valid, the counter for the winning rule, or the miss counter, increments and saturates at all-ones.
- Counter read: registered, 1 cycle.
  - With i_cnt_clr, the counter clears after the read.
  - Clear and increment in the same cycle leave the counter at 1.
  - Reads of i_cnt_addr > RULE_NUM return 0.

## Timing
- Lookup latency is 2 cycles, fully pipelined, one lookup per cycle.
  - S1 registers the RULE_NUM match vector and the bank select.
  - S2 priority-encodes and registers the outputs.
- Bank consistency: S1 captures active_sel with the request, and S2 reads actions from that captured bank. A request accepted in the commit cycle uses the old bank; the next cycle's request uses the new bank.
- Reset values:
  - o_act_valid, o_act_hit, o_act_idx, o_act_data = 0.
  - o_cnt_valid, o_cnt_data = 0.
  - o_cfg_ready = 1.
  - active_sel = 0, FSM in IDLE.
  - All rule valid bits in both banks = 0, all counters = 0.
- Reset mid-COPY or with lookups in flight aborts everything; no outputs are produced for those lookups.

## Structure
- Add to parser_pkg:
  - lookup_rule_t, a packed struct {valid; [TYPE_NUM-1:0][TYPE_WIDTH-1:0] data, mask; [ACT_WIDTH-1:0] action}, sized from the existing TYPE_NUM and TYPE_WIDTH constants.
  - LOOKUP_IDX_WIDTH = $clog2(RULE_NUM).
- Sub-module parser_prio_enc: parametrised lowest-index-first encoder (vector → {hit, idx}), reused by later layers.
- Banks are flops (RULE_NUM is small). Counters are a flop array.

## Test plan
- Reset, then a lookup with type {0x08,0x00} → o_act_valid 2 cycles later, hit=0, miss counter = 1.
- Write rule 3 = {data 0x0800, mask 0xFFFF, action 0xA5}, commit, wait RULE_NUM+1 cycles; look up 0x0800 → hit=1, idx=3, data=0xA5.
- Rule 1 = wildcard (mask 0) and rule 3 exact: look up 0x0800 → idx=1. Then clear rule 1's valid bit and commit → idx=3.
- Back-to-back lookups straddling the commit cycle → the first uses the old action, the second the new one. Writes during COPY see o_cfg_ready=0 and are dropped.
- Preload the rule-0 counter to all-ones minus 1 and send 3 hits → it reads all-ones. Read with i_cnt_clr during a concurrent hit → the next read returns 1.
- Assert i_rst during COPY with 2 lookups in flight → no o_act_valid; state is reset; the old active rules are gone (valid=0).

Source files
------------

// File: rtl/parser_pkg.sv
// parser_pkg: shared parser constants, the type-rule record and its match helper
package parser_pkg;
  localparam int TYPE_NUM = 2;
  localparam int TYPE_WIDTH = 8;
  localparam int ACT_WIDTH = 64;
  localparam int RULE_NUM = 8;
  localparam int CNT_WIDTH = 32;
  localparam int LOOKUP_IDX_WIDTH = $clog2(RULE_NUM);
  typedef struct packed {
    logic valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] data;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] mask;
    logic [ACT_WIDTH-1:0] action;
  } lookup_rule_t;
  typedef enum logic {IDLE, COPY} cfgState_t;
  // Field layout of data/mask matches the flat type vector, so one masked compare covers all fields
  function automatic logic ruleMatch(lookup_rule_t rule, logic [TYPE_NUM*TYPE_WIDTH-1:0] typeData);
    return rule.valid && (((typeData ^ rule.data) & rule.mask) == '0);
  endfunction
endpackage

// File: rtl/parser_type_lookup_if.sv
// parser_type_lookup_if: lookup, rule-config and counter-read signals of one parser layer
interface parser_type_lookup_if
  import parser_pkg::*;
#(
  parameter int TYPE_NUM = parser_pkg::TYPE_NUM,
  parameter int TYPE_WIDTH = parser_pkg::TYPE_WIDTH,
  parameter int ACT_WIDTH = parser_pkg::ACT_WIDTH,
  parameter int RULE_NUM = parser_pkg::RULE_NUM,
  parameter int CNT_WIDTH = parser_pkg::CNT_WIDTH
);
  logic i_type_valid;
  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_type_data;
  logic o_act_valid;
  logic o_act_hit;
  logic [$clog2(RULE_NUM)-1:0] o_act_idx;
  logic [ACT_WIDTH-1:0] o_act_data;
  logic i_cfg_wr;
  logic [$clog2(RULE_NUM)-1:0] i_cfg_addr;
  lookup_rule_t i_cfg_rule;
  logic i_cfg_commit;
  logic o_cfg_ready;
  logic i_cnt_rd;
  logic [$clog2(RULE_NUM+1)-1:0] i_cnt_addr;
  logic i_cnt_clr;
  logic o_cnt_valid;
  logic [CNT_WIDTH-1:0] o_cnt_data;
  modport master (
    output i_type_valid, i_type_data, i_cfg_wr, i_cfg_addr, i_cfg_rule, i_cfg_commit,
    output i_cnt_rd, i_cnt_addr, i_cnt_clr,
    input o_act_valid, o_act_hit, o_act_idx, o_act_data, o_cfg_ready, o_cnt_valid, o_cnt_data
  );
  modport slave (
    input i_type_valid, i_type_data, i_cfg_wr, i_cfg_addr, i_cfg_rule, i_cfg_commit,
    input i_cnt_rd, i_cnt_addr, i_cnt_clr,
    output o_act_valid, o_act_hit, o_act_idx, o_act_data, o_cfg_ready, o_cnt_valid, o_cnt_data
  );
endinterface

// File: rtl/parser_prio_enc.sv
// parser_prio_enc: lowest-index-first priority encoder, vector to {hit, idx}
module parser_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic [N-1:0] vec,
  output logic hit,
  output logic [W-1:0] idx
);
  always_comb begin
    hit = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/parser_type_lookup.sv
// parser_type_lookup: double-banked masked type-rule lookup with hit/miss counters
module parser_type_lookup
  import parser_pkg::*;
#(
  parameter int RULE_NUM = parser_pkg::RULE_NUM,
  parameter int CNT_WIDTH = parser_pkg::CNT_WIDTH
) (
  input logic i_clk,
  input logic i_rst,
  parser_type_lookup_if.slave bus
);
  localparam int IW = $clog2(RULE_NUM);
  localparam int AW = $clog2(RULE_NUM + 1);
  lookup_rule_t bank [2][RULE_NUM];
  cfgState_t state, nextState;
  logic activeSel;
  logic [IW-1:0] copyPtr;
  logic cfgWr, cfgCommit;
  logic [RULE_NUM-1:0] match, s1Match;
  logic s1Valid, s1Sel, encHit;
  logic [IW-1:0] encIdx;
  logic [CNT_WIDTH-1:0] cnt [RULE_NUM+1];
  logic [RULE_NUM:0] cntInc, cntClr;
  logic [AW-1:0] incAddr;
  assign cfgWr = bus.i_cfg_wr && bus.o_cfg_ready;
  assign cfgCommit = bus.i_cfg_commit && bus.o_cfg_ready;
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = (state == IDLE) ? (bus.i_cfg_commit ? COPY : IDLE)
                                : (copyPtr == IW'(RULE_NUM - 1) ? IDLE : COPY);
  always_comb bus.o_cfg_ready = (state == IDLE);
  // COPY refills the new shadow from the new active bank so later edits start from the live set
  always_ff @(posedge i_clk)
    if (i_rst) begin
      activeSel <= 1'b0;
      copyPtr <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < RULE_NUM; r++) bank[b][r] <= '0;
    end else begin
      if (cfgWr) bank[~activeSel][bus.i_cfg_addr] <= bus.i_cfg_rule;
      if (cfgCommit) activeSel <= ~activeSel;
      if (state == COPY) bank[~activeSel][copyPtr] <= bank[activeSel][copyPtr];
      copyPtr <= (state == COPY) ? copyPtr + 1'b1 : '0;
    end
  always_comb begin
    match = '0;
    for (int r = 0; r < RULE_NUM; r++) match[r] = ruleMatch(bank[activeSel][r], bus.i_type_data);
  end
  parser_prio_enc #(.N(RULE_NUM), .W(IW)) prioEnc (.vec(s1Match), .hit(encHit), .idx(encIdx));
  // S2 reads the action from the bank captured in S1, not the current active bank
  always_ff @(posedge i_clk)
    if (i_rst) begin
      s1Valid <= 1'b0;
      s1Match <= '0;
      s1Sel <= 1'b0;
      bus.o_act_valid <= 1'b0;
      bus.o_act_hit <= 1'b0;
      bus.o_act_idx <= '0;
      bus.o_act_data <= '0;
    end else begin
      s1Valid <= bus.i_type_valid;
      s1Match <= match;
      s1Sel <= activeSel;
      bus.o_act_valid <= s1Valid;
      bus.o_act_hit <= s1Valid && encHit;
      bus.o_act_idx <= s1Valid ? encIdx : '0;
      bus.o_act_data <= (s1Valid && encHit) ? bank[s1Sel][encIdx].action : '0;
    end
  assign incAddr = bus.o_act_hit ? AW'(bus.o_act_idx) : AW'(RULE_NUM);
  always_comb begin
    cntInc = '0;
    cntClr = '0;
    for (int i = 0; i <= RULE_NUM; i++) begin
      cntInc[i] = bus.o_act_valid && (incAddr == AW'(i));
      cntClr[i] = bus.i_cnt_rd && bus.i_cnt_clr && (bus.i_cnt_addr == AW'(i));
    end
  end
  always_ff @(posedge i_clk)
    for (int i = 0; i <= RULE_NUM; i++)
      if (i_rst) cnt[i] <= '0;
      else if (cntClr[i]) cnt[i] <= CNT_WIDTH'(cntInc[i]);
      else if (cntInc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      bus.o_cnt_valid <= 1'b0;
      bus.o_cnt_data <= '0;
    end else begin
      bus.o_cnt_valid <= bus.i_cnt_rd;
      bus.o_cnt_data <= (bus.i_cnt_rd && bus.i_cnt_addr <= AW'(RULE_NUM)) ? cnt[bus.i_cnt_addr] : '0;
    end
endmodule

// File: tb/tb_parser_type_lookup.sv
// tb_parser_type_lookup: directed checks of lookup priority, bank commit, counters and reset
module tb_parser_type_lookup;
  import parser_pkg::*;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  lookup_rule_t rule;
  parser_type_lookup_if #(.CNT_WIDTH(4)) bus ();
  parser_type_lookup #(.CNT_WIDTH(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic lookup(input logic [15:0] t, input logic h, input logic [2:0] idx,
                        input logic [63:0] d, input string tag);
    bus.i_type_valid = 1;
    bus.i_type_data = t;
    tick();
    bus.i_type_valid = 0;
    tick();
    check({tag, ".valid"}, bus.o_act_valid, 1);
    check({tag, ".hit"}, bus.o_act_hit, h);
    check({tag, ".idx"}, bus.o_act_idx, idx);
    check({tag, ".data"}, bus.o_act_data, d);
    tick();
  endtask
  task automatic setRule(input logic [2:0] a, input logic v, input logic [15:0] d,
                         input logic [15:0] m, input logic [63:0] act);
    rule.valid = v;
    rule.data = d;
    rule.mask = m;
    rule.action = act;
    bus.i_cfg_rule = rule;
    bus.i_cfg_addr = a;
  endtask
  task automatic cfgWrite(input logic [2:0] a, input logic v, input logic [15:0] d,
                          input logic [15:0] m, input logic [63:0] act);
    setRule(a, v, d, m, act);
    bus.i_cfg_wr = 1;
    tick();
    bus.i_cfg_wr = 0;
  endtask
  task automatic commitWait(input string tag);
    bus.i_cfg_commit = 1;
    tick();
    bus.i_cfg_commit = 0;
    check({tag, ".busy"}, bus.o_cfg_ready, 0);
    repeat (RULE_NUM) tick();
    check({tag, ".ready"}, bus.o_cfg_ready, 1);
  endtask
  task automatic cntRead(input logic [3:0] a, input logic c, input logic [3:0] exp, input string tag);
    bus.i_cnt_rd = 1;
    bus.i_cnt_addr = a;
    bus.i_cnt_clr = c;
    tick();
    bus.i_cnt_rd = 0;
    bus.i_cnt_clr = 0;
    check({tag, ".valid"}, bus.o_cnt_valid, 1);
    check(tag, bus.o_cnt_data, exp);
  endtask
  task automatic hits(input int n, input logic [15:0] t);
    bus.i_type_valid = 1;
    bus.i_type_data = t;
    repeat (n) tick();
    bus.i_type_valid = 0;
    repeat (2) tick();
  endtask
  initial begin
    rst = 1;
    {bus.i_type_valid, bus.i_type_data, bus.i_cfg_wr, bus.i_cfg_addr, bus.i_cfg_commit} = '0;
    {bus.i_cnt_rd, bus.i_cnt_addr, bus.i_cnt_clr} = '0;
    bus.i_cfg_rule = '0;
    repeat (2) tick();
    rst = 0;
    check("rst.act_valid", bus.o_act_valid, 0);
    check("rst.act_hit", bus.o_act_hit, 0);
    check("rst.act_idx", bus.o_act_idx, 0);
    check("rst.act_data", bus.o_act_data, 0);
    check("rst.cnt_valid", bus.o_cnt_valid, 0);
    check("rst.cnt_data", bus.o_cnt_data, 0);
    check("rst.cfg_ready", bus.o_cfg_ready, 1);
    lookup(16'h0800, 0, 0, 0, "miss0");
    cntRead(8, 0, 1, "missCnt1");
    cfgWrite(3, 1, 16'h0800, 16'hFFFF, 64'hA5);
    commitWait("commit1");
    lookup(16'h0800, 1, 3, 64'hA5, "exact3");
    cfgWrite(1, 1, 16'h0000, 16'h0000, 64'h11);
    commitWait("commit2");
    lookup(16'h0800, 1, 1, 64'h11, "wild1");
    lookup(16'h1234, 1, 1, 64'h11, "wildAny");
    cfgWrite(1, 0, 16'h0000, 16'h0000, 64'h11);
    commitWait("commit3");
    lookup(16'h0800, 1, 3, 64'hA5, "exact3b");
    lookup(16'h1234, 0, 0, 0, "miss1");
    cfgWrite(3, 1, 16'h0800, 16'hFFFF, 64'hB6);
    bus.i_cfg_commit = 1;
    bus.i_type_valid = 1;
    bus.i_type_data = 16'h0800;
    tick();
    bus.i_cfg_commit = 0;
    tick();
    bus.i_type_valid = 0;
    check("straddleOld.valid", bus.o_act_valid, 1);
    check("straddleOld.data", bus.o_act_data, 64'hA5);
    tick();
    check("straddleNew.valid", bus.o_act_valid, 1);
    check("straddleNew.data", bus.o_act_data, 64'hB6);
    repeat (RULE_NUM - 3) tick();
    setRule(2, 1, 16'h0800, 16'hFFFF, 64'hCC);
    bus.i_cfg_wr = 1;
    check("copyWr.ready", bus.o_cfg_ready, 0);
    tick();
    bus.i_cfg_wr = 0;
    check("copyEnd.ready", bus.o_cfg_ready, 1);
    commitWait("commit4");
    lookup(16'h0800, 1, 3, 64'hB6, "dropped");
    cntRead(3, 1, 5, "rule3Clr");
    cntRead(3, 0, 0, "rule3After");
    cntRead(1, 0, 2, "rule1Cnt");
    cntRead(8, 0, 2, "missCnt2");
    cntRead(12, 0, 0, "oobRead");
    cfgWrite(0, 1, 16'h0A0A, 16'hFFFF, 64'h77);
    commitWait("commit5");
    hits(14, 16'h0A0A);
    cntRead(0, 0, 14, "rule0Pre");
    hits(3, 16'h0A0A);
    cntRead(0, 0, 15, "rule0Sat");
    bus.i_type_valid = 1;
    bus.i_type_data = 16'h0A0A;
    tick();
    bus.i_type_valid = 0;
    tick();
    cntRead(0, 1, 15, "rule0ClrHit");
    cntRead(0, 0, 1, "rule0After");
    bus.i_cfg_commit = 1;
    bus.i_type_valid = 1;
    bus.i_type_data = 16'h0800;
    tick();
    bus.i_cfg_commit = 0;
    rst = 1;
    tick();
    rst = 0;
    bus.i_type_valid = 0;
    check("abort.valid0", bus.o_act_valid, 0);
    check("abort.ready", bus.o_cfg_ready, 1);
    tick();
    check("abort.valid1", bus.o_act_valid, 0);
    tick();
    check("abort.valid2", bus.o_act_valid, 0);
    lookup(16'h0800, 0, 0, 0, "postRst0800");
    lookup(16'h0A0A, 0, 0, 0, "postRst0A0A");
    cntRead(0, 0, 0, "postRstCnt0");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
